// File: rtl/srl_delay_pkg.sv
// Shared constants and helpers for the SRL-based programmable delay line.
// The delay D is counted in accepted stream samples and lives in 1..32,
// the depth of one SRLC32E per data bit.
package srl_delay_pkg;

    // Physical depth of each SRL bit-lane.
    localparam int SRL_DEPTH = 32;

    // Tap address width of an SRLC32E (selects one of 32 taps).
    localparam int ADDR_W = 5;

    // Width of the delay register and of the history counter.
    localparam int DELAY_W = 6;

    // Legal range of the programmable delay.
    localparam logic [DELAY_W-1:0] DELAY_MIN = 6'd1;
    localparam logic [DELAY_W-1:0] DELAY_MAX = 6'd32;

    // The history counter saturates once the SRL is completely full.
    localparam logic [DELAY_W-1:0] FILL_MAX = 6'd32;

    // Controller view of the SRL history. It is not separately stored:
    // it is derived from fill_cnt against the active delay.
    //   ST_FILL : fewer than D valid samples held, inputs produce no output
    //   ST_RUN  : at least D valid samples held, one output per input
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } fill_state_e;

    // True when a requested delay can be programmed.
    function automatic logic delay_legal(input logic [DELAY_W-1:0] d);
        return (d >= DELAY_MIN) && (d <= DELAY_MAX);
    endfunction

endpackage

// File: rtl/srlvec.sv
// Vectorized SRL delay line: one 32-deep shift register per data bit,
// shifting on ce, with a combinational read tap selected by a.
// Tap 0 is the most recently shifted-in sample, tap n is n samples older.
// Contents are deliberately not reset; the controller decides which
// taps hold meaningful history.
module srlvec
    import srl_delay_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic              clk,
    input  logic              ce,
    input  logic [ADDR_W-1:0] a,
    input  logic [NBITS-1:0]  d,
    output logic [NBITS-1:0]  q
);

    for (genvar i = 0; i < NBITS; i++) begin : g_lane
        logic [SRL_DEPTH-1:0] sr;

        // Shift one bit-lane by one position on every enabled clock.
        always_ff @(posedge clk) begin
            if (ce) begin
                sr <= {sr[SRL_DEPTH-2:0], d[i]};
            end
        end

        assign q[i] = sr[a];
    end

endmodule

// File: rtl/srl_delay_ctrl.sv
// Stream controller for the SRL delay line. The SRL shifts once per
// accepted input sample, so the delay is measured in samples, not clocks.
// A saturating history counter suppresses output until D valid samples
// are present; after that each accepted sample emits the sample accepted
// D samples earlier, through a registered output stage.
//
// Handshake rule for both streams: a transfer happens on a rising clock
// edge where valid and ready are both high. valid, once high, holds with
// its data stable until that transfer. The input side is ready whenever the
// output register is empty or is being drained in the same cycle, so a
// stalled consumer freezes the SRL and the history counter.
module srl_delay_ctrl
    import srl_delay_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   in_data,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [NBITS-1:0]   out_data,

    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic               cfg_flush,
    output logic               cfg_err,

    output logic [DELAY_W-1:0] cur_delay,
    output logic               filled
);

    // Number of valid samples held in the SRL, saturating at its depth.
    logic [DELAY_W-1:0] fill_cnt;
    logic [DELAY_W-1:0] fill_next;

    logic               acc;
    logic               qualify;
    logic               cfg_legal;
    logic               cfg_apply;
    logic               cfg_reject;
    logic [ADDR_W-1:0]  tap_addr;
    logic [NBITS-1:0]   srl_q;
    fill_state_e        state;

    // Input side stalls only while a pending output is not being taken.
    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;

    // Configuration is accepted every cycle; illegal requests are flagged.
    assign cfg_ready  = 1'b1;
    assign cfg_legal  = delay_legal(cfg_delay);
    assign cfg_apply  = cfg_valid && cfg_legal;
    assign cfg_reject = cfg_valid && !cfg_legal;

    // FILL/RUN is a pure function of the history count and the delay.
    // Both are the pre-edge values, so a sample accepted in the same cycle
    // as a reconfiguration is decided by the old delay and old count.
    assign filled  = (fill_cnt >= cur_delay);
    assign state   = filled ? ST_RUN : ST_FILL;
    assign qualify = acc && (state == ST_RUN);

    // Tap D-1 before the shift holds the sample accepted D samples ago.
    // cur_delay never drops below 1, so this never underflows.
    assign tap_addr = ADDR_W'(cur_delay - DELAY_MIN);

    srlvec #(
        .NBITS (NBITS)
    ) u_srl (
        .clk (clk),
        .ce  (acc),
        .a   (tap_addr),
        .d   (in_data),
        .q   (srl_q)
    );

    // Next history count: grow per accepted sample, saturate at SRL depth;
    // a legal flush restarts history, keeping a sample accepted alongside it.
    always_comb begin
        fill_next = fill_cnt;
        if (acc && (fill_cnt < FILL_MAX)) begin
            fill_next = fill_cnt + 6'd1;
        end
        if (cfg_apply && cfg_flush) begin
            fill_next = acc ? 6'd1 : 6'd0;
        end
    end

    // History counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else begin
            fill_cnt <= fill_next;
        end
    end

    // Active delay register and one-cycle rejection pulse for bad requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_delay <= DELAY_MIN;
            cfg_err   <= 1'b0;
        end else begin
            if (cfg_apply) begin
                cur_delay <= cfg_delay;
            end
            cfg_err <= cfg_reject;
        end
    end

    // Output register: load the delayed sample on a qualifying accept,
    // otherwise drop valid once the consumer has taken the word. A pending
    // word is only replaced when the consumer takes it, since acc implies
    // in_ready, which implies the register is empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (qualify) begin
                out_valid <= 1'b1;
                out_data  <= srl_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Bench for srl_delay_ctrl: directed scenarios followed by randomized
// streams, compared cycle by cycle against a sample-history reference.
module tb_srl_delay_ctrl;

    localparam int NBITS = 8;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NBITS-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NBITS-1:0] out_data;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [5:0]       cfg_delay = '0;
    logic             cfg_flush = 1'b0;
    logic             cfg_err;
    logic [5:0]       cur_delay;
    logic             filled;

    always #5 clk = ~clk;

    srl_delay_ctrl #(
        .NBITS (NBITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_delay (cfg_delay),
        .cfg_flush (cfg_flush),
        .cfg_err   (cfg_err),
        .cur_delay (cur_delay),
        .filled    (filled)
    );

    // ---------------- scoreboard and reference state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [NBITS-1:0] exp_q[$];   // delayed samples still owed to the consumer
    logic [NBITS-1:0] hist[$];    // every accepted sample, newest at the back
    bit               m_ov;
    logic [NBITS-1:0] m_od;
    int               m_fill;
    int               m_d;
    bit               m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ov   = 1'b0;
        m_od   = '0;
        m_fill = 0;
        m_d    = 1;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    // One clock: drive inputs after the falling edge, compare the DUT with
    // the reference, then advance the reference over the rising edge.
    task automatic cycle(input bit iv, input logic [NBITS-1:0] id, input bit ordy,
                         input bit cv, input logic [5:0] cd, input bit cf);
        bit               acc;
        bit               legal;
        logic [NBITS-1:0] tmp;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        cfg_valid = cv;
        cfg_delay = cd;
        cfg_flush = cf;
        #1;
        check("in_ready", in_ready, !m_ov || ordy);
        check("out_valid", out_valid, m_ov);
        if (m_ov) check("out_data", out_data, m_od);
        check("cur_delay", cur_delay, m_d);
        check("filled", filled, m_fill >= m_d);
        check("cfg_err", cfg_err, m_err);
        check("cfg_ready", cfg_ready, 1);
        if (out_valid && ordy) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                tmp = exp_q.pop_front();
                check("sb_data", out_data, tmp);
            end
        end
        @(posedge clk);
        acc   = iv && (!m_ov || ordy);
        legal = cv && (cd >= 1) && (cd <= 32);
        if (acc && (m_fill >= m_d)) begin
            m_od = hist[hist.size() - m_d];
            m_ov = 1'b1;
            exp_q.push_back(m_od);
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        if (acc) begin
            hist.push_back(id);
            if (hist.size() > 64) void'(hist.pop_front());
        end
        if (acc && (m_fill < 32)) m_fill++;
        if (legal && cf) m_fill = acc ? 1 : 0;
        if (legal) m_d = int'(cd);
        m_err = cv && !legal;
    endtask

    // Assert reset between edges and confirm the asynchronous clear.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_filled", filled, 0);
        check("rst_cur_delay", cur_delay, 1);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_in_ready", in_ready, 1);
        model_reset();
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        cfg_flush = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic stream(input int first, input int last, input bit ordy);
        for (int i = first; i <= last; i++) cycle(1'b1, NBITS'(i), ordy, 1'b0, 6'd0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        do_reset();

        // D=1: first sample silent, then 0,1,2,... one clock behind.
        stream(0, 11, 1'b1);

        // D=32 from reset: 32 silent accepts, sample 32 pairs with 0.
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1, 6'd32, 1'b0);
        stream(0, 40, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 6'd0, 1'b0);

        // D=4 saturated, shrink to 2 without flush alongside an accept.
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1, 6'd4, 1'b0);
        stream(0, 39, 1'b1);
        cycle(1'b1, 8'd40, 1'b1, 1'b1, 6'd2, 1'b0);
        stream(41, 47, 1'b1);

        // D=2, grow to 6 with flush while accepting sample 100.
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1, 6'd2, 1'b0);
        stream(90, 99, 1'b1);
        cycle(1'b1, 8'd100, 1'b1, 1'b1, 6'd6, 1'b1);
        stream(101, 110, 1'b1);

        // Consumer stall for five clocks with input pending, then release.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'd111, 1'b0, 1'b0, 6'd0, 1'b0);
        stream(111, 120, 1'b1);

        // Illegal delays: 0, then 40 with flush requested.
        cycle(1'b1, 8'd121, 1'b1, 1'b1, 6'd0, 1'b0);
        cycle(1'b1, 8'd122, 1'b1, 1'b1, 6'd40, 1'b1);
        stream(123, 130, 1'b1);

        // Reset in the middle of a running stream.
        do_reset();
        stream(131, 135, 1'b1);

        // Randomized traffic, reconfiguration, flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom % 4) != 0,
                      NBITS'($urandom),
                      ($urandom % 4) != 0,
                      ($urandom % 16) == 0,
                      (($urandom % 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 8)),
                      ($urandom % 3) == 0);
            end
        end

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/srl_delay_ctrl.md
Name: srl_delay_ctrl

Overview:
Stream-side controller for the vectorized SRL delay line (srlvec, SRLC32E per bit, depth 32). It sequences the SRL shift-enable from a valid/ready stream, so the delay is counted in accepted samples, not clocks. It programs the tap address from a runtime delay register and tracks how much valid history the SRL holds. Output is suppressed until D valid samples are present. Sits between a producer stream and a downstream consumer that needs a sample-aligned programmable delay.

Parameters:
NBITS, 8, data width (number of SRL bit-lanes)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset (one clock; reset is async, active-low)
in_valid  in  1  input sample valid
in_ready  out  1  input accept; combinational = !out_valid || out_ready
in_data  in  NBITS  input sample
out_valid  out  1  delayed sample valid (registered)
out_ready  in  1  consumer accept
out_data  out  NBITS  delayed sample (registered)
cfg_valid  in  1  delay update request
cfg_ready  out  1  always 1 after reset
cfg_delay  in  6  requested delay D, legal 1..32
cfg_flush  in  1  with cfg_valid: discard stored history
cfg_err  out  1  one-cycle pulse: illegal cfg_delay rejected
cur_delay  out  6  active delay D
filled  out  1  fill_cnt >= cur_delay

Behaviour:
- Reset values: out_valid=0, out_data=0, cur_delay=1, fill_cnt=0, cfg_err=0, filled=0. SRL contents are not reset; fill_cnt alone defines valid history.
- Accept: acc = in_valid && in_ready.
- SRL: ce = acc, din = in_data, a = {0, cur_delay-1} (6-bit, bit5=0).
- Pairing: on acc, the SRL Q (pre-shift, tap D-1) holds sample k-D, where k is the sample being accepted.
- If acc and fill_cnt >= cur_delay: out_data <= Q, out_valid <= 1.
- If acc and fill_cnt < cur_delay: the sample is shifted in and no output is produced.
- out_valid clears on out_valid && out_ready with no new qualifying acc. Back-to-back accepts give a continuous stream.
- Latency: out_valid rises one clock after the qualifying accept.
- Stall: while out_valid && !out_ready, in_ready=0, ce=0, and out_data is held stable.
- fill_cnt: 6-bit, +1 per acc, saturates at 32 (never wraps).
- States, derived from filled: FILL (fill_cnt < D; inputs are consumed with no output) and RUN (fill_cnt >= D; one output per input).
- Config: on cfg_valid with 1 <= cfg_delay <= 32, cur_delay <= cfg_delay next cycle.
- Config without flush: fill_cnt is retained. An increased D re-enters FILL until the count catches up. A decreased D is immediately RUN if fill_cnt >= new D.
- Illegal cfg_delay (0 or 33..63): cur_delay and fill_cnt unchanged, cfg_err=1 for one cycle, cfg_flush ignored.
- Flush: fill_cnt <= 0, or 1 if acc occurs in the same cycle (that sample is retained as newest history).
- Simultaneous acc and cfg: the accepted sample uses the old cur_delay and old fill_cnt for its output decision and tap address. The new delay applies from the next cycle.
- A pending out_valid word is never altered by cfg.
- Reset mid-operation: all registers return to reset values immediately (async), and the in-flight output is dropped.

Decomposition:
- Shared package srl_delay_pkg: SRL_DEPTH=32, DELAY_W=6, DELAY_MIN=1, DELAY_MAX=32.
- Sub-module: existing srlvec #(NBITS), instantiated once. The controller logic (counter, config, output register) stays flat in srl_delay_ctrl.

Test Plan:
- Reset, D=1, in_valid=1 continuously with data 0,1,2,... and out_ready=1: first input produces no output. out_valid first rises one clock after the 2nd accept with out_data=0, then 1,2,... every cycle.
- cfg_delay=32 from reset, stream 0..40: 32 accepts produce no output. The 33rd accept (data 32) yields out_data=0 next cycle. Sample 40 pairs with out_data=8.
- Running at D=4 with fill_cnt saturated, cfg_delay=2 without flush: the next accept (sample k) outputs k-2, with no gap in out_valid.
- Running at D=2, cfg_delay=6 with cfg_flush=1 in the same cycle as accepting sample 100: samples 101..105 produce no output. Accepting 106 outputs 100 (fill restarts at 1).
- Hold out_ready=0 for 5 cycles while out_valid=1 and in_valid=1: in_ready=0, out_data is stable, fill_cnt is unchanged. Releasing out_ready resumes the sequence with no lost or duplicated samples.
- cfg_delay=0, then cfg_delay=40: cfg_err pulses once for each, cur_delay keeps its old value, and the stream is unaffected. Asserting rst_n=0 mid-stream clears out_valid, filled, and cur_delay=1 asynchronously.
